design1_wrapper: RTL and testbench



---
 rtl/design1_wrapper.sv | 150 +++++++++++++++
 tb/tb_design1_wrapper.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/design1_wrapper.sv
// Publish/consume burst test core: on a fire edge a producer pushes N_WORDS sequential
// words into a small FIFO while a throttled consumer drains it, checks the sequence and sums it.

module design1_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk1,
   input  logic              reset,
   input  logic              clr,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       cnt;

   // Storage is not reset; occupancy tracking alone defines what is valid.
   always_ff @(posedge clk1) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk1) begin
      if (reset || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
endmodule

module design1_wrapper #(
   parameter int              DATA_W  = 16,
   parameter int              N_WORDS = 16,
   parameter logic [DATA_W-1:0] SEED  = 16'h0100,
   parameter int              DEPTH   = 4,
   parameter int              STALL   = 0
) (
   input  logic              clk1,
   input  logic              reset,
   input  logic              fire,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        word_count,
   output logic [DATA_W-1:0] checksum
);
   localparam int SW = (STALL > 0) ? $clog2(STALL + 1) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic              fire_q, start, launch;
   logic [7:0]        prod_cnt;
   logic [DATA_W-1:0] prod_sum, prod_word;
   logic [SW-1:0]     stall_cnt;
   logic              seq_err;
   logic              push, pop, full, empty;
   logic [DATA_W-1:0] fifo_dout;

   assign start  = fire & ~fire_q;
   assign launch = start && (state != RUN);

   always_ff @(posedge clk1) begin
      if (reset) begin
         state  <= IDLE;
         fire_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         fire_q <= fire;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (word_count == 8'(N_WORDS)) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A simultaneous pop frees a slot, so a full FIFO can still take a word that cycle.
   assign prod_word = SEED + DATA_W'(prod_cnt);
   assign push      = (state == RUN) && (prod_cnt < 8'(N_WORDS)) && (!full || pop);
   assign pop       = (state == RUN) && !empty && (stall_cnt == '0);

   design1_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk1  (clk1),
      .reset (reset),
      .clr   (launch),
      .push  (push),
      .din   (prod_word),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk1) begin
      if (reset || launch) begin
         prod_cnt <= '0;
         prod_sum <= '0;
      end else if (push) begin
         prod_cnt <= prod_cnt + 8'd1;
         prod_sum <= prod_sum + prod_word;
      end
   end

   always_ff @(posedge clk1) begin
      if (reset || launch) begin
         word_count <= '0;
         checksum   <= '0;
         stall_cnt  <= '0;
         seq_err    <= 1'b0;
      end else if (pop) begin
         word_count <= word_count + 8'd1;
         checksum   <= checksum + fifo_dout;
         stall_cnt  <= SW'(STALL);
         if (fifo_dout != SEED + DATA_W'(word_count)) seq_err <= 1'b1;
      end else if (stall_cnt != '0) begin
         stall_cnt <= stall_cnt - 1'b1;
      end
   end

   assign pass = done && (checksum == prod_sum) && (word_count == 8'(N_WORDS)) && !seq_err;
endmodule

// File: tb/tb_design1_wrapper.sv
// Scoreboard bench: three instances (defaults, STALL=3, wrapping SEED); stimulus queues
// expected burst results, a monitor compares them when each done rises.

module tb_design1_wrapper;
   localparam int N = 16;

   logic        clk1 = 1'b0;
   logic [2:0]  rst  = 3'b111;
   logic [2:0]  fire = 3'b000;
   logic [2:0]  busy, done, pass;
   logic [7:0]  wc [3];
   logic [15:0] cs [3];
   logic [2:0]  done_d = 3'b000;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail  = 0;

   typedef struct {
      int          id;
      int          t_exp;
      logic [7:0]  cnt;
      logic [15:0] sum;
      logic        pass;
   } exp_t;
   exp_t sb[$];

   always #5 clk1 = ~clk1;
   always @(posedge clk1) cyc <= cyc + 1;

   design1_wrapper u0 (.clk1(clk1), .reset(rst[0]), .fire(fire[0]), .busy(busy[0]),
      .done(done[0]), .pass(pass[0]), .word_count(wc[0]), .checksum(cs[0]));
   design1_wrapper #(.STALL(3)) u1 (.clk1(clk1), .reset(rst[1]), .fire(fire[1]), .busy(busy[1]),
      .done(done[1]), .pass(pass[1]), .word_count(wc[1]), .checksum(cs[1]));
   design1_wrapper #(.SEED(16'hFFF8)) u2 (.clk1(clk1), .reset(rst[2]), .fire(fire[2]), .busy(busy[2]),
      .done(done[2]), .pass(pass[2]), .word_count(wc[2]), .checksum(cs[2]));

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] sum_words(input logic [15:0] seed, input int n);
      logic [15:0] s = '0;
      for (int i = 0; i < n; i++) s = s + seed + 16'(i);
      return s;
   endfunction

   function automatic logic [15:0] seed_of(input int k);
      return (k == 2) ? 16'hFFF8 : 16'h0100;
   endfunction

   // Start edge at the next posedge E0; done is visible at the negedge after E(lat).
   function automatic int latency(input int k);
      int st = (k == 1) ? 3 : 0;
      return 2 + (N - 1) * (st + 1) + 1;
   endfunction

   task automatic issue(input int k);
      exp_t e;
      @(negedge clk1);
      fire[k] = 1'b0;
      @(negedge clk1);
      fire[k] = 1'b1;
      e.id    = k;
      e.t_exp = cyc + 1 + latency(k);
      e.cnt   = 8'(N);
      e.sum   = sum_words(seed_of(k), N);
      e.pass  = 1'b1;
      sb.push_back(e);
   endtask

   function automatic int pending(input int k);
      int c = 0;
      foreach (sb[i]) if (sb[i].id == k) c++;
      return c;
   endfunction

   task automatic wait_drain(input int k, input int budget);
      int t = 0;
      while (pending(k) != 0 && t < budget) begin
         @(negedge clk1);
         t++;
      end
      if (pending(k) != 0) begin
         check($sformatf("timeout_dut%0d", k), pending(k), 0);
         for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].id == k) sb.delete(i);
      end
   endtask

   task automatic check_zero(input int k, input string tag);
      check($sformatf("%s_busy%0d", tag, k), int'(busy[k]), 0);
      check($sformatf("%s_done%0d", tag, k), int'(done[k]), 0);
      check($sformatf("%s_pass%0d", tag, k), int'(pass[k]), 0);
      check($sformatf("%s_wc%0d", tag, k), int'(wc[k]), 0);
      check($sformatf("%s_cs%0d", tag, k), int'(cs[k]), 0);
   endtask

   always @(negedge clk1) begin
      for (int k = 0; k < 3; k++) begin
         if (done[k] && !done_d[k]) begin
            int idx = -1;
            for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].id == k) idx = i;
            if (idx < 0) begin
               check($sformatf("unexpected_done%0d", k), 1, 0);
            end else begin
               check($sformatf("lat%0d", k), cyc, sb[idx].t_exp);
               check($sformatf("wc%0d", k), int'(wc[k]), int'(sb[idx].cnt));
               check($sformatf("cs%0d", k), int'(cs[k]), int'(sb[idx].sum));
               check($sformatf("pass%0d", k), int'(pass[k]), int'(sb[idx].pass));
               sb.delete(idx);
            end
         end
      end
      done_d <= done;
   end

   initial begin
      int t;
      // Reset held for three cycles, then one idle cycle.
      repeat (3) @(negedge clk1);
      for (int k = 0; k < 3; k++) check_zero(k, "rst");
      rst = 3'b000;
      @(negedge clk1);
      for (int k = 0; k < 3; k++) check_zero(k, "idle");

      // Default burst; fire stays high afterwards and must not retrigger.
      issue(0);
      wait_drain(0, 200);
      repeat (10) @(negedge clk1);
      check("hold_done0", int'(done[0]), 1);
      check("hold_busy0", int'(busy[0]), 0);
      check("hold_wc0", int'(wc[0]), N);

      // Throttled consumer: FIFO fills, result unchanged, done later.
      issue(1);
      wait_drain(1, 400);

      // Fire toggled during RUN is ignored.
      issue(0);
      repeat (5) @(negedge clk1);
      fire[0] = 1'b0;
      repeat (2) @(negedge clk1);
      fire[0] = 1'b1;
      wait_drain(0, 200);
      repeat (3) @(negedge clk1);
      check("toggle_busy0", int'(busy[0]), 0);

      // Reset after five words aborts the burst, then a clean burst follows.
      @(negedge clk1);
      fire[0] = 1'b0;
      @(negedge clk1);
      fire[0] = 1'b1;
      t = 0;
      while (wc[0] != 8'd5 && t < 100) begin
         @(negedge clk1);
         t++;
      end
      check("mid_wc5", int'(wc[0]), 5);
      rst[0]  = 1'b1;
      fire[0] = 1'b0;
      @(negedge clk1);
      rst[0] = 1'b0;
      check_zero(0, "abort");
      issue(0);
      wait_drain(0, 200);

      // Wrapping seed, then a repeat burst from DONE.
      issue(2);
      wait_drain(2, 200);
      issue(2);
      wait_drain(2, 200);

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
